// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes RISC-V instruction words into {immediate, format, illegal}
// and queues them in a DEPTH-entry FIFO. Latency: 1 cycle, push to head; no bypass.
// Backpressure: inReady = !full, from registered count only (no outReady term).
//
// Ports:
//   clock, resetN            rising-edge clock, async active-low reset
//   inValid/inReady          instruction word handshake (instruction, 32 bits)
//   outValid/outReady        head entry handshake
//   outImmediate/outFormat/outIllegal  decoded head entry, all zero while empty
//   count                    current occupancy

// Generic synchronous FIFO with a registered head. Push on full and pop on empty are ignored.
module imm_gen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != FULL);
  assign pop_ok  = pop_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (pop_ok)  head_d = head_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok) mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;
endmodule

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [31:0]            instruction,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [XLEN-1:0]        outImmediate,
  output logic [2:0]             outFormat,
  output logic                   outIllegal,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_BAD = 3'd7;

  typedef struct packed {
    logic            ill;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t      dec_dat, head_dat;
  logic [CW-1:0] count_q;
  logic        push, pop;

  // Decode before storage: only the extended immediate and format are queued.
  // Size casts of signed operands replicate instruction[31] up to XLEN.
  always_comb begin
    dec_dat     = '0;
    dec_dat.fmt = FMT_BAD;
    dec_dat.ill = 1'b1;
    case (instruction[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        dec_dat.fmt = FMT_I;
        dec_dat.ill = 1'b0;
        dec_dat.imm = XLEN'($signed(instruction[31:20]));
      end
      7'b0100011: begin
        dec_dat.fmt = FMT_S;
        dec_dat.ill = 1'b0;
        dec_dat.imm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
      end
      7'b1100011: begin
        dec_dat.fmt = FMT_B;
        dec_dat.ill = 1'b0;
        dec_dat.imm = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                     instruction[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_dat.fmt = FMT_U;
        dec_dat.ill = 1'b0;
        dec_dat.imm = XLEN'($signed({instruction[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_dat.fmt = FMT_J;
        dec_dat.ill = 1'b0;
        dec_dat.imm = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                     instruction[30:21], 1'b0}));
      end
      7'b0110011: begin
        dec_dat.fmt = FMT_R;
        dec_dat.ill = 1'b0;
      end
      default: ;
    endcase
  end

  assign inReady  = (count_q != FULL);
  assign outValid = (count_q != '0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  imm_gen_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetN),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (dec_dat),
    .rdata_o (head_dat),
    .count_o (count_q)
  );

  // Stale storage behind an empty FIFO must not leak onto the outputs.
  assign outImmediate = outValid ? head_dat.imm : '0;
  assign outFormat    = outValid ? head_dat.fmt : '0;
  assign outIllegal   = outValid ? head_dat.ill : 1'b0;
  assign count        = count_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share all inputs.
// Expected entries are queued when the bench predicts a push and compared on pop.
module tb_imm_gen_pipe;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetN, inValid, outReady;
  logic [31:0] instruction;

  logic        inReady32, outValid32, outIllegal32;
  logic [31:0] outImmediate32;
  logic [2:0]  outFormat32;
  logic [2:0]  count32;
  logic        inReady64, outValid64, outIllegal64;
  logic [63:0] outImmediate64;
  logic [2:0]  outFormat64;
  logic [2:0]  count64;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady32),
    .instruction(instruction), .outValid(outValid32), .outReady(outReady),
    .outImmediate(outImmediate32), .outFormat(outFormat32), .outIllegal(outIllegal32),
    .count(count32));

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady64),
    .instruction(instruction), .outValid(outValid64), .outReady(outReady),
    .outImmediate(outImmediate64), .outFormat(outFormat64), .outIllegal(outIllegal64),
    .count(count64));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] imm;   // 64-bit expectation; the 32-bit DUT uses the low half
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t tbl [13];
  vec_t cur;
  vec_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   mon_n;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int i);
    instruction = tbl[i].ins;
    cur         = tbl[i];
    inValid     = 1'b1;
  endtask

  task automatic drain();
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step();
  endtask

  // Scoreboard: occupancy model plus in-order expected entries, evaluated
  // mid-cycle for the transfer that happens at the coming rising edge.
  always @(negedge clock) begin
    if (mon_en && resetN) begin
      mon_n = sb.size();
      chk("count32", 64'(count32), 64'(mon_n));
      chk("count64", 64'(count64), 64'(mon_n));
      chk("outValid32", 64'(outValid32), 64'(mon_n != 0));
      chk("outValid64", 64'(outValid64), 64'(mon_n != 0));
      chk("inReady32", 64'(inReady32), 64'(mon_n != DEPTH));
      chk("inReady64", 64'(inReady64), 64'(mon_n != DEPTH));
      if (mon_n != 0) begin
        chk("imm32", 64'(outImmediate32), 64'(sb[0].imm[31:0]));
        chk("imm64", outImmediate64, sb[0].imm);
        chk("fmt32", 64'(outFormat32), 64'(sb[0].fmt));
        chk("fmt64", 64'(outFormat64), 64'(sb[0].fmt));
        chk("ill32", 64'(outIllegal32), 64'(sb[0].ill));
        chk("ill64", 64'(outIllegal64), 64'(sb[0].ill));
        if (outReady) void'(sb.pop_front());
      end else begin
        chk("empty_imm32", 64'(outImmediate32), 64'd0);
        chk("empty_imm64", outImmediate64, 64'd0);
        chk("empty_fmt", 64'({outFormat32, outFormat64}), 64'd0);
        chk("empty_ill", 64'({outIllegal32, outIllegal64}), 64'd0);
      end
      if (inValid && mon_n != DEPTH) sb.push_back(cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0}; // addi x1,x0,-1
    tbl[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0}; // sw x1,-4(x2)
    tbl[2]  = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0}; // beq x0,x0,-8
    tbl[3]  = '{32'h0000007F, 64'h0,                   3'd7, 1'b1}; // illegal
    tbl[4]  = '{32'h002081B3, 64'h0,                   3'd0, 1'b0}; // add x3,x1,x2
    tbl[5]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0}; // lui x5,0x12345
    tbl[6]  = '{32'h80000297, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // auipc x5,0x80000
    tbl[7]  = '{32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0}; // jal x1,-4
    tbl[8]  = '{32'h00812283, 64'h0000_0000_0000_0008, 3'd1, 1'b0}; // lw x5,8(x2)
    tbl[9]  = '{32'h30529073, 64'h0000_0000_0000_0305, 3'd1, 1'b0}; // csrw mtvec,x5
    tbl[10] = '{32'h00000000, 64'h0,                   3'd7, 1'b1}; // all-zero word
    tbl[11] = '{32'h00209863, 64'h0000_0000_0000_0010, 3'd3, 1'b0}; // bne x1,x2,+16
    tbl[12] = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // lui x5,0x80000

    resetN = 1'b0; inValid = 1'b0; outReady = 1'b0; instruction = '0; cur = tbl[0];
    step();
    chk("rst_count", 64'({count32, count64}), 64'd0);
    chk("rst_outValid", 64'({outValid32, outValid64}), 64'd0);
    chk("rst_inReady", 64'({inReady32, inReady64}), 64'b11);
    chk("rst_imm", outImmediate64 | 64'(outImmediate32), 64'd0);
    step();
    resetN = 1'b1;
    mon_en = 1'b1;

    // Single addi with the consumer always ready.
    outReady = 1'b1;
    drive(0);
    step();
    inValid = 1'b0;
    chk("addi_visible", 64'(outValid32), 64'd1);
    drain();

    // Store then branch, queued first, popped in order.
    outReady = 1'b0;
    drive(1); step();
    drive(2); step();
    inValid = 1'b0;
    chk("two_queued", 64'(count32), 64'd2);
    drain();

    // Whole table with a free-running consumer.
    outReady = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(i);
      step();
    end
    drain();

    // Random valid/ready mix.
    for (int i = 0; i < 60; i++) begin
      drive(i % 13);
      inValid  = 1'($urandom_range(0, 1));
      outReady = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Fill: 6 offered words, only DEPTH accepted; then drain with input still offered.
    outReady = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(k);
      step();
    end
    chk("full_count", 64'(count32), 64'(DEPTH));
    chk("full_inReady", 64'({inReady32, inReady64}), 64'd0);
    outReady = 1'b1;
    for (int k = 6; k < 12; k++) begin
      drive(k);
      step();
    end
    drain();

    // Asynchronous reset with three entries queued.
    outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(k);
      step();
    end
    inValid = 1'b0;
    chk("pre_rst_count", 64'(count32), 64'd3);
    #2;
    resetN = 1'b0;
    #1;
    sb.delete();
    chk("arst_outValid", 64'({outValid32, outValid64}), 64'd0);
    chk("arst_count", 64'({count32, count64}), 64'd0);
    chk("arst_inReady", 64'({inReady32, inReady64}), 64'b11);
    chk("arst_imm", 64'(outImmediate32), 64'd0);
    step();
    resetN = 1'b1;
    outReady = 1'b1;
    drive(7);
    step();
    inValid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, buffered successor to the datapath's combinational immediate extender.
- Accepts full 32-bit RISC-V instruction words over a valid/ready handshake and decodes the instruction format from the opcode.
- Builds the sign-extended XLEN-bit immediate and queues {immediate, format, illegal} in a DEPTH-entry FIFO for the execute stage.
- Sits between the fetch/decode register and the ALU operand mux, decoupling fetch from execute stalls.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- DEPTH, 4, FIFO entry count; power of two, minimum 2.

Ports:
- clock  input  1  rising-edge clock.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  instruction word presented.
- inReady  output  1  block can accept a word this cycle.
- instruction  input  32  raw instruction word.
- outValid  output  1  head entry available.
- outReady  input  1  consumer takes the head entry this cycle.
- outImmediate  output  XLEN  sign-extended immediate of the head entry.
- outFormat  output  3  head format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- outIllegal  output  1  head opcode is unrecognised.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (resetN low, asynchronous): head, tail and count go to 0; outValid=0, inReady=1. outImmediate, outFormat and outIllegal read 0 while the FIFO is empty. Reset asserted mid-operation discards all queued entries immediately. Deassertion takes effect at the next clock edge.
- Push = inValid && inReady. Pop = outValid && outReady.
- inReady = (count != DEPTH). This is combinational from registered count only, with no dependence on outReady, so a full FIFO does not accept a word even in a cycle with a simultaneous pop.
- outValid = (count != 0). Outputs are driven from the head entry register, with no combinational input-to-output path.
- Latency: a word pushed at edge N is visible at the outputs after edge N when the FIFO was empty. There is no flow-through bypass.
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Decode on opcode = instruction[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, immediate 0.
  - Anything else: format 7, outIllegal=1, immediate 0.
- Immediate construction, with sign bit instruction[31] replicated to XLEN:
  - I: instruction[31:20].
  - S: {instruction[31:25], instruction[11:7]}.
  - B: {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
  - U: {instruction[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - J: {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
- Decode happens before storage; the FIFO stores the immediate, format and illegal bit only, not the raw word.
- An illegal word is still queued normally; it is never dropped.
- Pop on empty and push on full are ignored, with no state change.

Test Plan:
- Reset, then push 0xFFF00093 (addi x1,x0,-1), outReady=1 -> one cycle later outValid=1, outImmediate=0xFFFFFFFF, outFormat=1, outIllegal=0; count returns to 0 after the pop.
- Push 0xFE112E23 (sw x1,-4(x2)) then 0xFE000CE3 (beq x0,x0,-8) -> entries pop in order with 0xFFFFFFFC/format 2, then 0xFFFFFFF8/format 3.
- XLEN=64, push 0x800002B7 (lui x5,0x80000) -> outImmediate=0xFFFFFFFF80000000, format 4. Push 0x123452B7 -> 0x0000000012345000.
- Push 0x0000007F -> outIllegal=1, outFormat=7, outImmediate=0, entry queued and popped normally.
- DEPTH=4, outReady=0, inValid held high for 6 cycles -> exactly 4 accepted, inReady=0 from the cycle count reaches 4, count=4. Raising outReady with inValid high -> one pop per cycle; pushes resume only after count<4; order preserved across pointer wrap.
- With count=3, assert resetN low asynchronously between edges -> outValid=0, count=0, inReady=1 immediately. After release, the first pushed word is the first popped.
